// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding,
// default watchdog depth and the bundle of per-stage control outputs.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DWAIT = 2'd1,
    CTRL_IWAIT = 2'd2
  } ctrl_state_e;

  localparam int MAX_STALL_DEF = 16;

  typedef struct packed {
    logic pc_we;
    logic pc_redirect;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic memwb_we;
  } ctrl_out_t;

endpackage

// File: rtl/stall_watchdog.sv
// Saturating count of consecutive stalled cycles with a sticky timeout flag
// that only the asynchronous reset clears.
module stall_watchdog #(
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout;

  // next counter value: clear wins, increment holds at the saturation point
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      w_cnt_nxt = r_cnt + LP_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // counter and sticky flag; the flag rises on the edge the count reaches the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= r_timeout | (w_cnt_nxt == LP_MAX);
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazards, redirects and
// memory waits into per-stage controls. Optional perf counters: HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = MAX_STALL_DEF,
  parameter int CNT_W     = 5,
  parameter int PERF_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_branch,
  input  logic       stall_load_use,
  input  logic       branch_taken,
  input  logic       jump,
  input  logic       exmem_mem_en,
  input  logic       dmem_ready,
  input  logic       imem_ready,
  output logic       pc_we,
  output logic       pc_redirect,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_we,
  output logic       idex_flush,
  output logic       exmem_we,
  output logic       memwb_we,
  output logic [1:0] ctrl_state,
  output logic       stall_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_dwait_cyc
`endif
);

  if ((MAX_STALL < 2) || (MAX_STALL >= (1 << CNT_W)) || (PERF_W < 1)) begin : g_bad_params
    $error("pipeline_hazard_ctrl: illegal MAX_STALL/CNT_W/PERF_W combination");
  end

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;
  ctrl_out_t   w_ctl;
  logic        w_hz;
  logic        w_redir;
  logic        w_dmiss;
  logic        w_imiss;
  logic        w_freeze;

  assign w_hz    = stall_branch | stall_load_use;
  assign w_redir = (branch_taken | jump) & ~w_hz;
  assign w_dmiss = exmem_mem_en & ~dmem_ready;
  assign w_imiss = ~imem_ready;
  // DWAIT keeps the whole pipe frozen until the data access completes
  assign w_freeze = w_dmiss | ((r_state == CTRL_DWAIT) & ~dmem_ready);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CTRL_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode; a hazard stall postpones entering IWAIT but does not leave it
  always_comb begin
    w_state_nxt = CTRL_RUN;
    case (r_state)
      CTRL_RUN, CTRL_DWAIT: begin
        if (w_freeze) begin
          w_state_nxt = CTRL_DWAIT;
        end else if (!w_hz && w_imiss) begin
          w_state_nxt = CTRL_IWAIT;
        end else begin
          w_state_nxt = CTRL_RUN;
        end
      end
      CTRL_IWAIT: begin
        if (w_freeze) begin
          w_state_nxt = CTRL_DWAIT;
        end else if (w_imiss) begin
          w_state_nxt = CTRL_IWAIT;
        end else begin
          w_state_nxt = CTRL_RUN;
        end
      end
      default: w_state_nxt = CTRL_RUN;
    endcase
  end

  // output decode in priority order: freeze, hazard, fetch miss, redirect, normal
  always_comb begin
    w_ctl = '0;
    if (rst || w_freeze) begin
      w_ctl = '0;
    end else if (w_hz) begin
      w_ctl.idex_we    = 1'b1;
      w_ctl.idex_flush = 1'b1;
      w_ctl.exmem_we   = 1'b1;
      w_ctl.memwb_we   = 1'b1;
    end else if (w_imiss) begin
      w_ctl.pc_we       = w_redir;
      w_ctl.pc_redirect = w_redir;
      w_ctl.ifid_we     = 1'b1;
      w_ctl.ifid_flush  = 1'b1;
      w_ctl.idex_we     = 1'b1;
      w_ctl.exmem_we    = 1'b1;
      w_ctl.memwb_we    = 1'b1;
    end else begin
      w_ctl.pc_we       = 1'b1;
      w_ctl.pc_redirect = w_redir;
      w_ctl.ifid_we     = 1'b1;
      w_ctl.ifid_flush  = w_redir;
      w_ctl.idex_we     = 1'b1;
      w_ctl.exmem_we    = 1'b1;
      w_ctl.memwb_we    = 1'b1;
    end
  end

  assign pc_we       = w_ctl.pc_we;
  assign pc_redirect = w_ctl.pc_redirect;
  assign ifid_we     = w_ctl.ifid_we;
  assign ifid_flush  = w_ctl.ifid_flush;
  assign idex_we     = w_ctl.idex_we;
  assign idex_flush  = w_ctl.idex_flush;
  assign exmem_we    = w_ctl.exmem_we;
  assign memwb_we    = w_ctl.memwb_we;
  assign ctrl_state  = r_state;

  // a RUN cycle that is merely entering DWAIT neither counts nor clears
  stall_watchdog #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_inc     ((r_state != CTRL_RUN) | w_hz),
    .i_clr     ((r_state == CTRL_RUN) & ~w_hz & ~w_dmiss),
    .o_timeout (stall_timeout)
  );

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] LP_PERF_ONE = PERF_W'(1);

  logic w_all_we_off;
  assign w_all_we_off = ~(w_ctl.pc_we | w_ctl.ifid_we | w_ctl.idex_we |
                          w_ctl.exmem_we | w_ctl.memwb_we);

  // free-running event counters, wrapping at 2^PERF_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_dwait_cyc <= '0;
    end else begin
      perf_stall_cyc <= perf_stall_cyc + ((w_hz & ~w_dmiss) ? LP_PERF_ONE : '0);
      perf_flush_cnt <= perf_flush_cnt + (w_ctl.pc_redirect ? LP_PERF_ONE : '0);
      perf_dwait_cyc <= perf_dwait_cyc + (w_all_we_off ? LP_PERF_ONE : '0);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven, scoreboarded bench for pipeline_hazard_ctrl (MAX_STALL=4).
module tb_pipeline_hazard_ctrl;

  localparam int MAX_STALL = 4;
  localparam int CNT_W     = 3;
  localparam int PERF_W    = 32;
  localparam int NVEC      = 29;

  // {pc_we,pc_redirect,ifid_we,ifid_flush,idex_we,idex_flush,exmem_we,memwb_we}
  localparam logic [7:0] O_NORM  = 8'b1010_1011;
  localparam logic [7:0] O_FRZ   = 8'b0000_0000;
  localparam logic [7:0] O_HZ    = 8'b0000_1111;
  localparam logic [7:0] O_IMISS = 8'b0011_1011;
  localparam logic [7:0] O_REDIR = 8'b1111_1011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall_branch, stall_load_use, branch_taken, jump;
  logic       exmem_mem_en, dmem_ready, imem_ready;
  logic       pc_we, pc_redirect, ifid_we, ifid_flush, idex_we, idex_flush;
  logic       exmem_we, memwb_we;
  logic [1:0] ctrl_state;
  logic       stall_timeout;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_cyc, perf_flush_cnt, perf_dwait_cyc;
`endif

  logic [7:0] w_out;
  assign w_out = {pc_we, pc_redirect, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we};

  pipeline_hazard_ctrl #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W),
    .PERF_W    (PERF_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_branch   (stall_branch),
    .stall_load_use (stall_load_use),
    .branch_taken   (branch_taken),
    .jump           (jump),
    .exmem_mem_en   (exmem_mem_en),
    .dmem_ready     (dmem_ready),
    .imem_ready     (imem_ready),
    .pc_we          (pc_we),
    .pc_redirect    (pc_redirect),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .idex_we        (idex_we),
    .idex_flush     (idex_flush),
    .exmem_we       (exmem_we),
    .memwb_we       (memwb_we),
    .ctrl_state     (ctrl_state),
    .stall_timeout  (stall_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_dwait_cyc (perf_dwait_cyc)
`endif
  );

  always #5 clk = ~clk;

  // inputs packed as {stall_branch,stall_load_use,branch_taken,jump,exmem_mem_en,dmem_ready,imem_ready}
  typedef struct {
    logic [6:0] in;
    logic [7:0] out;
    logic [1:0] st;
    logic       to;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic [1:0] st;
    logic       to;
    int         idx;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {stall_branch, stall_load_use, branch_taken, jump, exmem_mem_en, dmem_ready, imem_ready} = v;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_t e;
    drive(7'b0000011);

    vecs[0]  = '{7'b0000011, O_NORM,  2'd0, 1'b0};
    vecs[1]  = '{7'b1000011, O_HZ,    2'd0, 1'b0};
    vecs[2]  = '{7'b1000011, O_HZ,    2'd0, 1'b0};
    vecs[3]  = '{7'b0010011, O_REDIR, 2'd0, 1'b0};
    vecs[4]  = '{7'b1110011, O_HZ,    2'd0, 1'b0};
    vecs[5]  = '{7'b0011011, O_REDIR, 2'd0, 1'b0};
    vecs[6]  = '{7'b0000101, O_FRZ,   2'd0, 1'b0};
    vecs[7]  = '{7'b0000101, O_FRZ,   2'd1, 1'b0};
    vecs[8]  = '{7'b0000101, O_FRZ,   2'd1, 1'b0};
    vecs[9]  = '{7'b0000111, O_NORM,  2'd1, 1'b0};
    vecs[10] = '{7'b0000011, O_NORM,  2'd0, 1'b0};
    vecs[11] = '{7'b0001010, O_REDIR, 2'd0, 1'b0};
    vecs[12] = '{7'b0000010, O_IMISS, 2'd2, 1'b0};
    vecs[13] = '{7'b0000011, O_NORM,  2'd2, 1'b0};
    vecs[14] = '{7'b0000011, O_NORM,  2'd0, 1'b0};
    vecs[15] = '{7'b0000010, O_IMISS, 2'd0, 1'b0};
    vecs[16] = '{7'b0000100, O_FRZ,   2'd2, 1'b0};
    vecs[17] = '{7'b0000011, O_NORM,  2'd1, 1'b0};
    vecs[18] = '{7'b1000010, O_HZ,    2'd0, 1'b0};
    vecs[19] = '{7'b0000011, O_NORM,  2'd0, 1'b0};
    vecs[20] = '{7'b0000101, O_FRZ,   2'd0, 1'b0};
    vecs[21] = '{7'b0000101, O_FRZ,   2'd1, 1'b0};
    vecs[22] = '{7'b0000101, O_FRZ,   2'd1, 1'b0};
    vecs[23] = '{7'b0000101, O_FRZ,   2'd1, 1'b0};
    vecs[24] = '{7'b0000101, O_FRZ,   2'd1, 1'b0};
    vecs[25] = '{7'b0000101, O_FRZ,   2'd1, 1'b1};
    vecs[26] = '{7'b0000111, O_NORM,  2'd1, 1'b1};
    vecs[27] = '{7'b0000011, O_NORM,  2'd0, 1'b1};
    vecs[28] = '{7'b0000011, O_NORM,  2'd0, 1'b1};

    // reset held: everything off even though inputs are idle
    @(negedge clk);
    chk("reset_outputs", 32'(w_out), 32'(O_FRZ));
    chk("reset_state", 32'(ctrl_state), 32'd0);
    chk("reset_timeout", 32'(stall_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].in);
      sb_q.push_back('{vecs[i].out, vecs[i].st, vecs[i].to, i});
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("vec%0d_outputs", e.idx), 32'(w_out), 32'(e.out));
      chk($sformatf("vec%0d_state", e.idx), 32'(ctrl_state), 32'(e.st));
      chk($sformatf("vec%0d_timeout", e.idx), 32'(stall_timeout), 32'(e.to));
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // asynchronous reset in the middle of a data wait
    @(posedge clk); #1;
    drive(7'b0000101);
    @(posedge clk); #1;
    @(negedge clk);
    chk("predwait_state", 32'(ctrl_state), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(ctrl_state), 32'd0);
    chk("async_rst_outputs", 32'(w_out), 32'(O_FRZ));
    chk("async_rst_timeout", 32'(stall_timeout), 32'd0);
    #1 rst = 1'b0;
    drive(7'b0000011);
    @(negedge clk);
    chk("post_rst_outputs", 32'(w_out), 32'(O_NORM));
    chk("post_rst_state", 32'(ctrl_state), 32'd0);

`ifdef HAZARD_PERF_EN
    // 3 hazard cycles, 2 redirects, 4 frozen cycles, then idle
    @(posedge clk); #1 rst = 1'b1;
    #1 rst = 1'b0;
    drive(7'b1000011);
    @(posedge clk); #1 drive(7'b0100011);
    @(posedge clk); #1 drive(7'b1100011);
    @(posedge clk); #1 drive(7'b0010011);
    @(posedge clk); #1 drive(7'b0001011);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 drive(7'b0000101);
    end
    @(posedge clk); #1 drive(7'b0000111);
    @(negedge clk);
    chk("perf_stall_cyc", perf_stall_cyc, 32'd3);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
    chk("perf_dwait_cyc", perf_dwait_cyc, 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
